// File: rtl/hart_dmem_responder.sv
// hart_dmem_responder: data-memory responder for the single-cycle hart.
// Byte-addressed little-endian RAM with zero-latency reads and an MMIO window
// holding a free-running cycle counter and a console TX FIFO.
// Optional build macro: HART_DMEM_FAULT_EN. When defined, o_fault pulses for
// one cycle after an unmapped access. When undefined, o_fault is tied low.
module hart_dmem_responder #(
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
  parameter int          TX_DEPTH    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_fault
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = PW + 1;

  // Region decode
  logic       ram_hit;
  logic       mmio_hit;
  logic [1:0] mmio_off;

  assign ram_hit  = (i_dmem_addr < 32'(DEPTH_BYTES));
  assign mmio_hit = (i_dmem_addr >= MMIO_BASE) && (i_dmem_addr < (MMIO_BASE + 32'd16));
  assign mmio_off = i_dmem_addr[3:2];

  // RAM bank; each lane index wraps inside the bank so unaligned words
  // straddling the top of RAM continue at byte 0.
  logic [7:0]    ram [DEPTH_BYTES];
  logic [AW-1:0] lane_idx [4];
  logic [7:0]    rd_lane  [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_idx[gi] = i_dmem_addr[AW-1:0] + AW'(gi);
      assign rd_lane[gi]  = ram[lane_idx[gi]];
    end
  endgenerate

  // Byte-masked RAM write; contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (i_dmem_wen && ram_hit) begin
      for (int n = 0; n < 4; n++) begin
        if (i_dmem_mask[n]) ram[lane_idx[n]] <= i_dmem_wdata[8*n +: 8];
      end
    end
  end

  // Free-running cycle counter
  logic [31:0] cycle_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cycle_reg <= '0;
    else          cycle_reg <= cycle_reg + 32'd1;
  end

  // Console TX FIFO state
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic          fifo_empty, fifo_full;
  logic          push_req, push_ok, pop, ovf_clr;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(TX_DEPTH));
  assign pop        = !fifo_empty && i_tx_ready;
  assign push_req   = i_dmem_wen && mmio_hit && (mmio_off == 2'd1) && i_dmem_mask[0];
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_clr    = i_dmem_wen && mmio_hit && (mmio_off == 2'd2) &&
                      i_dmem_mask[0] && i_dmem_wdata[0];

  // FIFO next-state: pointers, occupancy and sticky overflow (set beats clear)
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + PW'(1);
    if (pop)     rd_ptr_next = rd_ptr_reg + PW'(1);
    if (push_ok && !pop)      count_next = count_reg + CW'(1);
    else if (!push_ok && pop) count_next = count_reg - CW'(1);
    if (ovf_clr)                      ovf_next = 1'b0;
    if (push_req && fifo_full && !pop) ovf_next = 1'b1;
  end

  // FIFO control registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  // FIFO storage; entries are meaningless once the pointers reset
  always_ff @(posedge i_clk) begin
    if (push_ok) tx_mem[wr_ptr_reg] <= i_dmem_wdata[7:0];
  end

  assign o_tx_valid = !fifo_empty;
  assign o_tx_data  = tx_mem[rd_ptr_reg];

  // Load data mux; zero when idle or unmapped
  logic [31:0] tx_stat;
  assign tx_stat = {16'b0, 8'(count_reg), 5'b0, ovf_reg, fifo_full, fifo_empty};

  always_comb begin
    o_dmem_rdata = '0;
    if (i_dmem_ren) begin
      if (ram_hit) begin
        o_dmem_rdata = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
      end else if (mmio_hit) begin
        case (mmio_off)
          2'd0:    o_dmem_rdata = cycle_reg;
          2'd1:    o_dmem_rdata = tx_stat;
          default: o_dmem_rdata = '0;
        endcase
      end
    end
  end

`ifdef HART_DMEM_FAULT_EN
  logic fault_reg;

  // One-cycle pulse after any access that hit neither RAM nor MMIO
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fault_reg <= 1'b0;
    else          fault_reg <= (i_dmem_ren || i_dmem_wen) && !ram_hit && !mmio_hit;
  end

  assign o_fault = fault_reg;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_hart_dmem_responder.sv
// Scoreboard bench for hart_dmem_responder: loads and console bytes are
// queued with their expected values when issued, and a negedge monitor
// compares whatever the DUT presents.
module tb_hart_dmem_responder;

  localparam logic [31:0] MB = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        ready = 1'b0;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];

  hart_dmem_responder dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_dmem_addr  (addr),
    .i_dmem_ren   (ren),
    .i_dmem_wen   (wen),
    .i_dmem_wdata (wdata),
    .i_dmem_mask  (mask),
    .o_dmem_rdata (rdata),
    .o_tx_valid   (tx_valid),
    .o_tx_data    (tx_data),
    .i_tx_ready   (ready),
    .o_fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: compares load data and console bytes as the DUT presents them
  always @(negedge clk) begin
    logic [31:0] e32;
    logic [7:0]  e8;
    if (ren) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL load_unexpected @%h: got %h, expected no load", addr, rdata);
      end else begin
        e32 = rd_q.pop_front();
        check32($sformatf("load@%h", addr), rdata, e32);
      end
    end else if (rdata !== 32'h0) begin
      checks++; errors++;
      $display("FAIL rdata_idle: got %h, expected 00000000", rdata);
    end
    if (tx_valid && ready) begin
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got %h, expected no byte", tx_data);
      end else begin
        e8 = tx_q.pop_front();
        check32("tx_byte", {24'b0, tx_data}, {24'b0, e8});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp);
    addr = a; ren = 1'b1;
    rd_q.push_back(exp);
    step();
    ren = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; mask = m; wen = 1'b1;
    step();
    wen = 1'b0;
  endtask

  task automatic do_rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_old);
    addr = a; wdata = d; mask = 4'hF; wen = 1'b1; ren = 1'b1;
    rd_q.push_back(exp_old);
    step();
    wen = 1'b0; ren = 1'b0;
  endtask

  // Push a console byte; expect_out=0 marks a byte that must be dropped
  task automatic do_push(input logic [7:0] b, input bit expect_out);
    if (expect_out) tx_q.push_back(b);
    do_store(MB + 32'd4, {24'b0, b}, 4'b0001);
  endtask

  task automatic drain();
    int n;
    ready = 1'b1;
    n = 0;
    while ((tx_valid || tx_q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", tx_q.size());
    end
    ready = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    check32("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check32("rst_fault", {31'b0, fault}, 32'h0);
    do_load(MB, 32'h0);
    do_load(MB + 32'd4, 32'h0000_0001);

    // Cycle counter: 10 edges after release reads 10, next cycle 11
    rst_n = 1'b1;
    repeat (10) step();
    do_load(MB, 32'd10);
    do_load(MB, 32'd11);

    // RAM byte lanes, unaligned and wrap
    do_store(32'h0, 32'h0, 4'hF);
    do_store(32'h14, 32'h0, 4'hF);
    do_store(32'h10, 32'hDEAD_BEEF, 4'hF);
    do_load(32'h10, 32'hDEAD_BEEF);
    do_store(32'h10, 32'h0000_00AA, 4'b0001);
    do_load(32'h10, 32'hDEAD_BEAA);
    do_load(32'h11, 32'h00DE_ADBE);
    do_rw(32'h10, 32'h1234_5678, 32'hDEAD_BEAA);
    do_load(32'h10, 32'h1234_5678);
    do_store(32'h3FE, 32'h1122_3344, 4'hF);
    do_load(32'h3FE, 32'h1122_3344);
    do_load(32'h0, 32'h0000_1122);
    do_store(32'h400, 32'hFFFF_FFFF, 4'hF);
    do_load(32'h0, 32'h0000_1122);
    do_load(32'h400, 32'h0);

    // MMIO read-zero registers
    do_load(MB + 32'd8, 32'h0);
    do_load(MB + 32'd12, 32'h0);

    // Overflow: nine pushes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) do_push(8'(8'h41 + i), i < 8);
    do_load(MB + 32'd4, 32'h0000_0806);
    drain();
    do_load(MB + 32'd4, 32'h0000_0005);
    do_store(MB + 32'd8, 32'h1, 4'b0001);
    do_load(MB + 32'd4, 32'h0000_0001);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) do_push(8'(8'h50 + i), 1'b1);
    ready = 1'b1;
    do_push(8'h58, 1'b1);
    ready = 1'b0;
    do_load(MB + 32'd4, 32'h0000_0802);
    drain();

    // Empty FIFO with push and ready together: byte stored, popped later
    ready = 1'b1;
    do_push(8'h60, 1'b1);
    drain();
    do_load(MB + 32'd4, 32'h0000_0001);

    // Unmapped load
    do_load(32'h8000_0000, 32'h0);
`ifdef HART_DMEM_FAULT_EN
    check32("fault_pulse", {31'b0, fault}, 32'h1);
`else
    check32("fault_pulse", {31'b0, fault}, 32'h0);
`endif
    step();
    check32("fault_clear", {31'b0, fault}, 32'h0);

    // Asynchronous reset with bytes queued
    do_store(MB + 32'd4, 32'h70, 4'b0001);
    do_store(MB + 32'd4, 32'h71, 4'b0001);
    check32("tx_valid_before_rst", {31'b0, tx_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check32("tx_valid_async_rst", {31'b0, tx_valid}, 32'h0);
    step();
    rst_n = 1'b1;
    do_load(MB + 32'd4, 32'h0000_0001);

    step();
    check32("rd_queue_empty", rd_q.size(), 32'h0);
    check32("tx_queue_empty", tx_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hart_dmem_responder.md
Name: hart_dmem_responder

Overview:
- Responder end of the hart data-memory interface: serves loads and stores issued by the single-cycle hart.
- Provides a byte-addressed little-endian RAM bank.
- Provides a small MMIO window: a free-running cycle counter and a console TX FIFO drained through a valid/ready byte stream.
- Sits beside the hart in the SoC top in place of the behavioural data memory.

Parameters:
- DEPTH_BYTES, 1024: RAM size in bytes, power of two; RAM occupies addresses 0 to DEPTH_BYTES-1.
- MMIO_BASE, 32'h0000_1000: base address of the MMIO window; 16-byte window, word-aligned.
- TX_DEPTH, 8: console FIFO entries, power of two, 2 to 128.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_dmem_addr, input, 32: byte address from hart.
- i_dmem_ren, input, 1: load request.
- i_dmem_wen, input, 1: store request.
- i_dmem_wdata, input, 32: store data, little-endian lanes.
- i_dmem_mask, input, 4: byte-lane enables; bit n covers wdata[8n+7:8n].
- o_dmem_rdata, output, 32: load data, combinational.
- o_tx_valid, output, 1: console byte available.
- o_tx_data, output, 8: console byte at FIFO head.
- i_tx_ready, input, 1: console sink accepts byte.
- o_fault, output, 1: out-of-range access indicator (see Optional Feature).

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - Cycle counter = 0.
  - FIFO empty; read/write pointers = 0.
  - Overflow flag = 0; o_tx_valid = 0; o_fault = 0.
  - RAM contents are not cleared.
  - o_dmem_rdata follows the read rules below.
- Region decode:
  - RAM: i_dmem_addr < DEPTH_BYTES.
  - MMIO: MMIO_BASE <= i_dmem_addr < MMIO_BASE+16.
  - Anything else is unmapped.
- RAM read, zero latency:
  - When ren=1, o_dmem_rdata = {b[a+3], b[a+2], b[a+1], b[a]}.
  - Byte indices wrap modulo DEPTH_BYTES; unaligned addresses are legal.
  - The mask is ignored on reads.
- RAM write: on the rising edge with wen=1, write byte b[a+n] = wdata lane n for each set mask bit n, with the same wrap rule.
- o_dmem_rdata = 0 whenever ren=0, or when the address is unmapped.
- Same-cycle ren and wen: the read returns pre-write contents; the write commits at the edge.
- MMIO registers (offset from MMIO_BASE; low 2 address bits ignored):
  - 0x0 CYCLE (RO):
    - 32-bit counter, +1 every clock after reset release.
    - Wraps FFFF_FFFF to 0.
    - Reads return the current registered value; writes are ignored.
  - 0x4 TXDATA (W) / TXSTAT (R):
    - Write with mask[0]=1 pushes wdata[7:0] into the FIFO.
    - Read returns {16'b0, count[7:0], 5'b0, overflow, full, empty}.
  - 0x8 CTRL (W): a write with wdata[0]=1 and mask[0]=1 clears the overflow flag. Reads return 0.
  - 0xC: reserved; reads return 0, writes are ignored.
- FIFO rules:
  - Pop when o_tx_valid and i_tx_ready at the edge.
  - o_tx_valid = !empty; o_tx_data = head entry, stable until popped.
  - Push is accepted if not full, or if a pop occurs in the same cycle. Push and pop on a full FIFO leaves count unchanged.
  - Push while full with no pop: byte dropped, overflow set (sticky).
  - Overflow set and CTRL clear in the same cycle: set wins.
  - Push and pop on an empty FIFO: the push is stored and nothing is popped (o_tx_valid was 0).
  - Pointers wrap modulo TX_DEPTH; count ranges 0 to TX_DEPTH.
- Reset mid-operation: FIFO contents are discarded and o_tx_valid drops immediately (asynchronous).

Optional Feature:
- Macro: HART_DMEM_FAULT_EN.
- Defined: o_fault is a registered one-cycle pulse. It asserts the cycle after any edge where (ren or wen) was asserted with an unmapped address. Unmapped writes are ignored and unmapped reads return 0.
- Undefined: o_fault is tied 0; unmapped reads still return 0 and unmapped writes are still ignored.

Test Plan:
- Store word at 0x10 (wdata=0xDEADBEEF, mask=1111), then load 0x10 -> rdata=0xDEADBEEF. Store at 0x10 (wdata=0x000000AA, mask=0001), then load -> 0xDEADBEAA.
- Store word at DEPTH_BYTES-2 (0x3FE, wdata=0x11223344, mask=1111), then load 0x3FE -> 0x11223344; load 0x0 -> low half = 0x1122.
- Release reset, wait 10 clocks, load MMIO_BASE -> value 10 (±1 per the documented sample edge). Force the counter to FFFF_FFFF -> it reads 0 the next cycle.
- Hold i_tx_ready=0 and push bytes 0x41..0x49 (9 pushes, TX_DEPTH=8) -> TXSTAT = count 8, full=1, overflow=1. Raise ready -> 0x41..0x48 drained in order. Write CTRL=1 -> overflow=0, empty=1.
- With the FIFO full, push and pop in the same cycle -> count stays 8, the new byte is appended at the tail, overflow unchanged.
- With HART_DMEM_FAULT_EN, load 0x8000_0000 -> rdata=0 and o_fault high for exactly 1 cycle. Without the macro -> o_fault stays 0.
